fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  PC register, next-PC select and IF/ID pipeline register for the 5-stage RV32I core.
//  Consumes the load-use hazard unit's stall/write-enable and the EX-stage redirect.
//  Feeds {pc, inst, valid} to ID; optionally sequences precise interrupt entry and mret return.
// PARAMETERS
//  XLEN          32            datapath / PC width
//  RESET_PC      32'h0000_0000 PC value loaded by reset
//  DRAIN_CYCLES  2             bubbles issued before vectoring (covers ID, EX)
// PORTS
//  clk                 in   1     single clock, rising edge
//  rst                 in   1     synchronous, active-high reset
//  is_stall            in   1     load-use stall from hazard unit
//  if_id_write_enable  in   1     0 = hold IF/ID register (hazard unit)
//  branch_taken        in   1     EX-stage redirect (branch/jal/jalr)
//  branch_target       in   XLEN  redirect address, valid with branch_taken
//  imem_addr           out  XLEN  instruction-memory address (= pc, combinational)
//  imem_rdata          in   32    instruction word, same-cycle read
//  irq                 in   1     level interrupt request (already gated by mstatus.MIE)
//  mtvec               in   XLEN  trap vector base
//  mret                in   1     mret in EX, one-cycle pulse
//  if_id_pc            out  XLEN  PC of instruction in ID
//  if_id_inst          out  32    instruction in ID
//  if_id_valid         out  1     0 = bubble
//  irq_ack             out  1     one-cycle pulse on vectoring
//  epc                 out  XLEN  return address for CSR mepc
// BEHAVIOUR
//  Reset: pc=RESET_PC, if_id_inst=NOP (32'h0000_0013), if_id_pc=0, if_id_valid=0,
//   irq_ack=0, epc=0, state=RUN, drain count=0. Reset overrides every other event.
//  Next-PC priority (high->low): rst, vector (DRAIN done), mret, branch_taken, hold, pc+4.
//  Hold: is_stall=1 -> pc unchanged; if_id_write_enable=0 -> IF/ID unchanged.
//  branch_taken: pc<=branch_target; IF/ID <= NOP, valid=0 (flush). Overrides stall.
//  Normal: IF/ID <= {pc, imem_rdata, 1}; pc<=pc+4; wraps modulo 2^XLEN.
//  FSM RUN / DRAIN / HANDLER:
//   RUN: irq=1, is_stall=0, branch_taken=0 -> epc<=pc, cnt<=DRAIN_CYCLES, go DRAIN;
//     that edge captures a bubble (fetched instr discarded, pc held).
//   irq with stall or branch in the same cycle -> deferred; re-evaluated next cycle.
//   DRAIN: pc held, IF/ID <= bubble; cnt decrements only when is_stall=0;
//     branch_taken -> epc<=branch_target, pc not changed;
//     cnt==0 -> pc<=mtvec, irq_ack=1 for one cycle, go HANDLER.
//   HANDLER: normal fetch; irq ignored; mret -> pc<=epc, flush IF/ID, go RUN.
//   mret in RUN/DRAIN ignored (no pc change); irq dropping during DRAIN does not abort.
// CONFIGURATION
//  FETCH_IRQ_EN defined: FSM, epc, irq_ack and mret handling as above.
//  FETCH_IRQ_EN undefined: no FSM; irq/mtvec/mret ignored; irq_ack=0, epc=0 constant.
// STRUCTURE
//  fetch_pkg: XLEN, NOP_INST=32'h0000_0013, fetch_state_t {RUN, DRAIN, HANDLER}.
//  Sub-module if_id_reg: {pc, inst, valid} register with write-enable and flush (flush wins).
// TESTING
//  Reset, 3 free cycles, imem returns i0..i2 -> imem_addr 0,4,8; if_id_pc 0,4; valid=1.
//  is_stall=1, if_id_write_enable=0 for 1 cycle at pc=0x10 -> pc and IF/ID held; resume 0x14.
//  branch_taken=1, target=0x80, stall=1 same cycle -> pc=0x80, if_id_valid=0 next cycle.
//  irq at pc=0x20, mtvec=0x100 -> 2 bubbles, then irq_ack pulse, pc=0x100, epc=0x20.
//  irq then branch_taken to 0x40 during DRAIN -> epc=0x40; vector to mtvec unchanged.
//  HANDLER mret -> pc=epc, IF/ID flushed, state RUN; FETCH_IRQ_EN undefined -> irq no effect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Optional interrupt sequencing is enabled with FETCH_IRQ_EN.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HANDLER
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage and imem.
// Read data is returned in the same cycle as the address.
interface fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register with write-enable and flush.
// Flush wins over write-enable and inserts a NOP bubble.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we,
  input  logic   flush,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (flush) begin
      r_d.inst  = NOP_INST;
      r_d.valid = 1'b0;
    end else if (we) begin
      r_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.pc    <= '0;
      r_q.inst  <= NOP_INST;
      r_q.valid <= 1'b0;
    end else begin
      r_q <= r_d;
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/fetch_stage.sv
// PC register, next-PC select and IF/ID register of the RV32I core.
// Define FETCH_IRQ_EN for precise interrupt entry and mret return.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_stall,
  input  logic            if_id_write_enable,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  fetch_if.master         imem,
  input  logic            irq,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_valid,
  output logic            irq_ack,
  output logic [XLEN-1:0] epc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_nrm;
  logic            flush_nrm;
  logic            flush;
  if_id_t          ifid_in, ifid_out;

  always_comb begin
    pc_nrm    = pc_q + XLEN'(4);
    flush_nrm = 1'b0;
    if (branch_taken) begin
      pc_nrm    = branch_target;
      flush_nrm = 1'b1;
    end else if (is_stall) begin
      pc_nrm = pc_q;
    end
  end

`ifdef FETCH_IRQ_EN
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  fetch_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            irq_ack_q, irq_ack_d;

  always_comb begin
    pc_d      = pc_nrm;
    flush     = flush_nrm;
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    irq_ack_d = 1'b0;
    unique case (state_q)
      RUN: begin
        // Entry edge discards the fetched word and holds pc.
        if (irq && !is_stall && !branch_taken) begin
          pc_d    = pc_q;
          flush   = 1'b1;
          epc_d   = pc_q;
          cnt_d   = CW'(DRAIN_CYCLES);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        pc_d  = pc_q;
        flush = 1'b1;
        if (branch_taken) epc_d = branch_target;
        if (cnt_q == '0) begin
          pc_d      = mtvec;
          irq_ack_d = 1'b1;
          state_d   = HANDLER;
        end else if (!is_stall) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HANDLER: begin
        if (mret) begin
          pc_d    = epc_q;
          flush   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      epc_q     <= '0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign irq_ack = irq_ack_q;
  assign epc     = epc_q;
`else
  logic unused_irq;

  always_comb begin
    pc_d  = pc_nrm;
    flush = flush_nrm;
  end

  assign unused_irq = ^{irq, mtvec, mret};
  assign irq_ack    = 1'b0;
  assign epc        = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign imem.imem_addr = pc_q;

  assign ifid_in.pc    = pc_q;
  assign ifid_in.inst  = imem.imem_rdata;
  assign ifid_in.valid = 1'b1;

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .we    (if_id_write_enable),
    .flush (flush),
    .din   (ifid_in),
    .dout  (ifid_out)
  );

  assign if_id_pc    = ifid_out.pc;
  assign if_id_inst  = ifid_out.inst;
  assign if_id_valid = ifid_out.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] TAG = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst, is_stall, if_id_write_enable;
  logic        branch_taken, irq, mret;
  logic [31:0] branch_target, mtvec;
  logic [31:0] if_id_pc, if_id_inst, epc;
  logic        if_id_valid, irq_ack;

  always #5 clk = ~clk;

  fetch_if bus ();

  // Instruction word encodes its own address so ID contents are checkable.
  assign bus.imem_rdata = TAG ^ bus.imem_addr;

  fetch_stage dut (
    .clk                (clk),
    .rst                (rst),
    .is_stall           (is_stall),
    .if_id_write_enable (if_id_write_enable),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .imem               (bus),
    .irq                (irq),
    .mtvec              (mtvec),
    .mret               (mret),
    .if_id_pc           (if_id_pc),
    .if_id_inst         (if_id_inst),
    .if_id_valid        (if_id_valid),
    .irq_ack            (irq_ack),
    .epc                (epc)
  );

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] idpc;
    logic        chk_pc;
    logic        ack;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, ".addr"}, bus.imem_addr, e.addr);
        chk({e.nm, ".valid"}, 32'(if_id_valid), 32'(e.vld));
        chk({e.nm, ".ack"}, 32'(irq_ack), 32'(e.ack));
        chk({e.nm, ".epc"}, epc, e.epc);
        if (e.vld)
          chk({e.nm, ".inst"}, if_id_inst, TAG ^ e.idpc);
        else
          chk({e.nm, ".inst"}, if_id_inst, NOP_INST);
        if (e.chk_pc)
          chk({e.nm, ".idpc"}, if_id_pc, e.idpc);
      end
    end
  end

  task automatic step(
    string nm, logic r, logic st, logic we, logic br,
    logic [31:0] tgt, logic iq, logic mr,
    logic [31:0] addr, logic vld, logic [31:0] idpc,
    logic ack, logic [31:0] ep
  );
    exp_t e;
    rst                = r;
    is_stall           = st;
    if_id_write_enable = we;
    branch_taken       = br;
    branch_target      = tgt;
    irq                = iq;
    mret               = mr;
    @(posedge clk);
    e = '{nm, addr, vld, idpc, vld | r, ack, ep};
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(string nm, logic [31:0] addr,
                     logic [31:0] idpc, logic [31:0] ep);
    step(nm, 0, 0, 1, 0, 0, 0, 0, addr, 1, idpc, 0, ep);
  endtask

  initial begin
    mtvec = 32'h100;
    step("rst0", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run("f0", 32'h04, 32'h00, 0);
    run("f1", 32'h08, 32'h04, 0);
    run("f2", 32'h0C, 32'h08, 0);
    run("f3", 32'h10, 32'h0C, 0);
    step("hold", 0, 1, 0, 0, 0, 0, 0, 32'h10, 1, 32'h0C, 0, 0);
    run("resume", 32'h14, 32'h10, 0);
    run("f5", 32'h18, 32'h14, 0);
    step("br_stall", 0, 1, 1, 1, 32'h80, 0, 0, 32'h80, 0, 0, 0, 0);
    run("br_next", 32'h84, 32'h80, 0);
    step("we0", 0, 0, 0, 0, 0, 0, 0, 32'h88, 1, 32'h80, 0, 0);
    step("br_we0", 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0,
         32'hFFFF_FFF8, 0, 0, 0, 0);
    run("wrap0", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 0);
    run("wrap1", 32'h0000_0000, 32'hFFFF_FFFC, 0);
    run("wrap2", 32'h0000_0004, 32'h0000_0000, 0);
    step("br_1c", 0, 0, 1, 1, 32'h1C, 0, 0, 32'h1C, 0, 0, 0, 0);
    run("at20", 32'h20, 32'h1C, 0);
`ifdef FETCH_IRQ_EN
    step("irq_in", 0, 0, 1, 0, 0, 1, 0, 32'h20, 0, 0, 0, 32'h20);
    step("drain2", 0, 0, 1, 0, 0, 0, 0, 32'h20, 0, 0, 0, 32'h20);
    step("drain1", 0, 0, 1, 0, 0, 0, 0, 32'h20, 0, 0, 0, 32'h20);
    step("vector", 0, 0, 1, 0, 0, 0, 0, 32'h100, 0, 0, 1, 32'h20);
    step("hdl", 0, 0, 1, 0, 0, 1, 0, 32'h104, 1, 32'h100, 0, 32'h20);
    step("mret", 0, 0, 1, 0, 0, 0, 1, 32'h20, 0, 0, 0, 32'h20);
    run("ret_f", 32'h24, 32'h20, 32'h20);
    step("irq_stall", 0, 1, 0, 0, 0, 1, 0, 32'h24, 1, 32'h20, 0, 32'h20);
    step("irq_in2", 0, 0, 1, 0, 0, 1, 0, 32'h24, 0, 0, 0, 32'h24);
    step("drain_br", 0, 0, 1, 1, 32'h40, 1, 0, 32'h24, 0, 0, 0, 32'h40);
    step("drain_st", 0, 1, 1, 0, 0, 0, 0, 32'h24, 0, 0, 0, 32'h40);
    step("drain_end", 0, 0, 1, 0, 0, 0, 0, 32'h24, 0, 0, 0, 32'h40);
    step("vector2", 0, 0, 1, 0, 0, 0, 0, 32'h100, 0, 0, 1, 32'h40);
    step("hdl_mret", 0, 0, 1, 0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h40);
    run("ret_f2", 32'h44, 32'h40, 32'h40);
    step("mret_run", 0, 0, 1, 0, 0, 0, 1, 32'h48, 1, 32'h44, 0, 32'h40);
`else
    step("irq_off", 0, 0, 1, 0, 0, 1, 0, 32'h24, 1, 32'h20, 0, 0);
    step("irq_off2", 0, 0, 1, 0, 0, 1, 0, 32'h28, 1, 32'h24, 0, 0);
    step("mret_off", 0, 0, 1, 0, 0, 1, 1, 32'h2C, 1, 32'h28, 0, 0);
`endif
    step("rst_br", 1, 0, 1, 1, 32'h80, 1, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    branch_taken = 1'b0;
    irq = 1'b0;
    mret = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
